// File: rtl/piso_shift_serializer.sv
// rtl/piso_shift_serializer.sv - parallel-in/serial-out shift stage with valid/ready load and done pulse
module piso_shift_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [WIDTH-1:0]         load_data,
  input  logic                     shift_en,
  output logic                     ser_out,
  output logic                     ser_out_bar,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shifted;

  // Head moves toward the output end; the vacated end fills with zero.
  assign shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                             : {1'b0, shreg_q[WIDTH-1:1]};

  // Serial line is taken straight from the register head, no input path.
  assign ser_out     = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign ser_out_bar = ~ser_out;
  assign bit_cnt     = cnt_q;

  // State, shift register and bit counter; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and status outputs; everything holds unless a case moves it.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    load_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          shreg_d = load_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (shift_en) begin
          shreg_d = shifted;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/piso_shift_serializer.md
Name: piso_shift_serializer

Overview:
Parallel-in/serial-out shift register stage built on the team's D flip-flop cells. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per enabled clock. It reports progress through busy, a bit counter and a one-cycle done pulse. It sits directly downstream of the word producer and drives the serial line consumed by the bit-level logic.

Parameters:
WIDTH, 8, word length in bits; must be >= 2.
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous active-high reset.
load_valid  input  1  producer offers load_data.
load_ready  output  1  block can accept a word this cycle.
load_data  input  WIDTH  parallel word to serialize.
shift_en  input  1  shift tick; the register advances only when this is high.
ser_out  output  1  current serial bit (head of the shift register).
ser_out_bar  output  1  always ~ser_out.
busy  output  1  high in SHIFT state.
done  output  1  one-cycle pulse after the last bit leaves.
bit_cnt  output  $clog2(WIDTH)  number of bits already shifted out of the current word.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named rst.
- Reset: rst is sampled at the rising edge of clk and has priority over everything else. After a reset edge:
  - state = IDLE, shift register = 0, bit_cnt = 0.
  - ser_out = 0, ser_out_bar = 1.
  - load_ready = 1, busy = 0, done = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - load_ready = 1.
  - A handshake (load_valid && load_ready) at edge k loads shreg <= load_data, clears bit_cnt to 0 and moves to SHIFT.
  - ser_out shows the first bit immediately after edge k: load_data[WIDTH-1] if MSB_FIRST, else load_data[0].
  - shift_en is ignored in IDLE.
- SHIFT:
  - load_ready = 0 and busy = 1.
  - At each edge with shift_en = 1, the register shifts one position toward the head and a 0 fills the vacated end.
  - MSB_FIRST=1 shifts left; MSB_FIRST=0 shifts right.
  - If bit_cnt < WIDTH-1, bit_cnt increments.
  - If bit_cnt == WIDTH-1, bit_cnt returns to 0 and the state moves to DONE. The register is all zeros at that point, so ser_out = 0.
  - shift_en = 0 stalls: the register, bit_cnt and state all hold.
  - Each bit is therefore visible from one enabled edge until the next.
- DONE:
  - done = 1, busy = 0, load_ready = 0, lasting exactly one cycle.
  - The next edge moves to IDLE unconditionally.
- ser_out = head bit of the register: bit WIDTH-1 if MSB_FIRST, else bit 0. It is purely a register-output function with no combinational path from the inputs.
- load_valid while load_ready = 0 is ignored, and load_data is not sampled. The producer must hold the word until load_ready.
- rst during SHIFT or DONE aborts the word. No done pulse is produced, and the reset values apply after that edge.
- Latency: with shift_en held at 1, load edge k gives:
  - bits visible after edges k .. k+WIDTH-1;
  - done high after edge k+WIDTH;
  - load_ready high after edge k+WIDTH+1.
- Minimum word-to-word period is WIDTH+2 cycles.

Test Plan:
1. Reset values: hold rst = 1 for 2 edges with load_valid = 1 and shift_en = 1 -> ser_out = 0, ser_out_bar = 1, load_ready = 1, busy = 0, done = 0, bit_cnt = 0, and no load occurs.
2. Basic serialization: WIDTH = 8, MSB_FIRST = 1, load 8'hA5 at edge k, shift_en = 1 throughout.
   - ser_out after edges k..k+7 = 1,0,1,0,0,1,0,1.
   - bit_cnt = 0..7 over the same edges.
   - done = 1 only after edge k+8, with ser_out = 0.
   - load_ready = 1 after edge k+9.
3. Stall: repeat scenario 2 with shift_en = 1 on every third cycle only -> the same bit sequence, each bit held 3 cycles, busy continuously high, done after the 8th enabled edge.
4. LSB-first: MSB_FIRST = 0, load 8'hA5 -> ser_out sequence 1,0,1,0,0,1,0,1 (bits 0..7); load 8'h01 -> 1,0,0,0,0,0,0,0.
5. Busy load rejection: during SHIFT of 8'hF0, assert load_valid with load_data = 8'h0F -> load_ready = 0, the output remains 1,1,1,1,0,0,0,0, and the first accepted load after done takes 8'h0F.
6. Reset mid-word: load 8'hFF and assert rst after 3 shifts -> after that edge ser_out = 0, bit_cnt = 0, busy = 0, load_ready = 1, and done never pulses.
